// File: rtl/decode.sv
// RV32I instruction decoder: one-cycle registered decode with combinational rs1/rs2 taps.
// Define RV32M_EN to also accept the M-extension OP encodings (d_op 38..45).
module decode (
   input  logic        clk,
   input  logic        rstn,
   input  logic        enabled,
   input  logic [31:0] pc,
   input  logic [31:0] instr_raw,
   output logic        completed,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [31:0] d_pc,
   output logic [31:0] d_raw,
   output logic [4:0]  d_rd,
   output logic [31:0] d_imm,
   output logic [5:0]  d_op,
   output logic        d_jal,
   output logic        d_jalr,
   output logic        d_cond_jump,
   output logic        d_writes_rd,
   output logic        d_mret,
   output logic        d_ecall,
   output logic        d_ebreak,
   output logic        d_illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   logic [31:0] imm_nxt;
   logic [5:0]  op_nxt;
   logic        jal_nxt, jalr_nxt, cond_nxt, rd_class, writes_nxt;
   logic        mret_nxt, ecall_nxt, ebreak_nxt, illegal_nxt;

   assign rs1    = instr_raw[19:15];
   assign rs2    = instr_raw[24:20];
   assign opcode = instr_raw[6:0];
   assign funct3 = instr_raw[14:12];
   assign funct7 = instr_raw[31:25];
   assign rd     = instr_raw[11:7];

   assign imm_i = {{20{instr_raw[31]}}, instr_raw[31:20]};
   assign imm_s = {{20{instr_raw[31]}}, instr_raw[31:25], instr_raw[11:7]};
   assign imm_b = {{19{instr_raw[31]}}, instr_raw[31], instr_raw[7], instr_raw[30:25],
                   instr_raw[11:8], 1'b0};
   assign imm_u = {instr_raw[31:12], 12'h000};
   assign imm_j = {{11{instr_raw[31]}}, instr_raw[31], instr_raw[19:12], instr_raw[20],
                   instr_raw[30:21], 1'b0};

   always_comb begin
      op_nxt      = 6'd0;
      imm_nxt     = 32'h0;
      jal_nxt     = 1'b0;
      jalr_nxt    = 1'b0;
      cond_nxt    = 1'b0;
      rd_class    = 1'b0;
      writes_nxt  = 1'b0;
      mret_nxt    = 1'b0;
      ecall_nxt   = 1'b0;
      ebreak_nxt  = 1'b0;
      illegal_nxt = 1'b0;

      if (opcode[1:0] != 2'b11) begin
         illegal_nxt = 1'b1;
      end else begin
         case (opcode[6:2])
            5'b01101: begin // lui
               op_nxt   = 6'd1;
               imm_nxt  = imm_u;
               rd_class = 1'b1;
            end
            5'b00101: begin // auipc
               op_nxt   = 6'd2;
               imm_nxt  = imm_u;
               rd_class = 1'b1;
            end
            5'b11011: begin
               op_nxt   = 6'd3;
               imm_nxt  = imm_j;
               jal_nxt  = 1'b1;
               rd_class = 1'b1;
            end
            5'b11001: begin
               op_nxt      = 6'd4;
               imm_nxt     = imm_i;
               jalr_nxt    = 1'b1;
               rd_class    = 1'b1;
               illegal_nxt = (funct3 != 3'b000);
            end
            5'b11000: begin
               imm_nxt  = imm_b;
               cond_nxt = 1'b1;
               case (funct3)
                  3'b000:  op_nxt = 6'd5;
                  3'b001:  op_nxt = 6'd6;
                  3'b100:  op_nxt = 6'd7;
                  3'b101:  op_nxt = 6'd8;
                  3'b110:  op_nxt = 6'd9;
                  3'b111:  op_nxt = 6'd10;
                  default: illegal_nxt = 1'b1;
               endcase
            end
            5'b00000: begin
               imm_nxt  = imm_i;
               rd_class = 1'b1;
               case (funct3)
                  3'b000:  op_nxt = 6'd11;
                  3'b001:  op_nxt = 6'd12;
                  3'b010:  op_nxt = 6'd13;
                  3'b100:  op_nxt = 6'd14;
                  3'b101:  op_nxt = 6'd15;
                  default: illegal_nxt = 1'b1;
               endcase
            end
            5'b01000: begin
               imm_nxt = imm_s;
               case (funct3)
                  3'b000:  op_nxt = 6'd16;
                  3'b001:  op_nxt = 6'd17;
                  3'b010:  op_nxt = 6'd18;
                  default: illegal_nxt = 1'b1;
               endcase
            end
            5'b00100: begin
               imm_nxt  = imm_i;
               rd_class = 1'b1;
               case (funct3)
                  3'b000: op_nxt = 6'd19;
                  3'b010: op_nxt = 6'd20;
                  3'b011: op_nxt = 6'd21;
                  3'b100: op_nxt = 6'd22;
                  3'b110: op_nxt = 6'd23;
                  3'b111: op_nxt = 6'd24;
                  3'b001: begin
                     op_nxt      = 6'd25;
                     illegal_nxt = (funct7 != 7'b0000000);
                  end
                  default: begin // 3'b101: srli / srai
                     if (funct7 == 7'b0000000)      op_nxt = 6'd26;
                     else if (funct7 == 7'b0100000) op_nxt = 6'd27;
                     else                           illegal_nxt = 1'b1;
                  end
               endcase
            end
            5'b01100: begin
               rd_class = 1'b1;
               if (funct7 == 7'b0000000) begin
                  case (funct3)
                     3'b000:  op_nxt = 6'd28;
                     3'b001:  op_nxt = 6'd30;
                     3'b010:  op_nxt = 6'd31;
                     3'b011:  op_nxt = 6'd32;
                     3'b100:  op_nxt = 6'd33;
                     3'b101:  op_nxt = 6'd34;
                     3'b110:  op_nxt = 6'd36;
                     default: op_nxt = 6'd37;
                  endcase
               end else if (funct7 == 7'b0100000) begin
                  case (funct3)
                     3'b000:  op_nxt = 6'd29;
                     3'b101:  op_nxt = 6'd35;
                     default: illegal_nxt = 1'b1;
                  endcase
               end else if (funct7 == 7'b0000001) begin
`ifdef RV32M_EN
                  op_nxt = 6'd38 + {3'b000, funct3};
`else
                  illegal_nxt = 1'b1;
`endif
               end else begin
                  illegal_nxt = 1'b1;
               end
            end
            5'b00011: ; // fence: legal, no operation code, no writeback
            5'b11100: begin
               if (instr_raw == 32'h3020_0073)      mret_nxt    = 1'b1;
               else if (instr_raw == 32'h0000_0073) ecall_nxt   = 1'b1;
               else if (instr_raw == 32'h0010_0073) ebreak_nxt  = 1'b1;
               else                                 illegal_nxt = 1'b1;
            end
            default: illegal_nxt = 1'b1;
         endcase
      end

      // An illegal word must not leak partial decode into op, immediate or flags.
      if (illegal_nxt) begin
         op_nxt   = 6'd0;
         imm_nxt  = 32'h0;
         jal_nxt  = 1'b0;
         jalr_nxt = 1'b0;
         cond_nxt = 1'b0;
         rd_class = 1'b0;
      end
      writes_nxt = rd_class && (rd != 5'd0);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         completed   <= 1'b0;
         d_pc        <= 32'h0;
         d_raw       <= 32'h0;
         d_rd        <= 5'd0;
         d_imm       <= 32'h0;
         d_op        <= 6'd0;
         d_jal       <= 1'b0;
         d_jalr      <= 1'b0;
         d_cond_jump <= 1'b0;
         d_writes_rd <= 1'b0;
         d_mret      <= 1'b0;
         d_ecall     <= 1'b0;
         d_ebreak    <= 1'b0;
         d_illegal   <= 1'b0;
      end else if (enabled) begin
         completed   <= 1'b1;
         d_pc        <= pc;
         d_raw       <= instr_raw;
         d_rd        <= rd;
         d_imm       <= imm_nxt;
         d_op        <= op_nxt;
         d_jal       <= jal_nxt;
         d_jalr      <= jalr_nxt;
         d_cond_jump <= cond_nxt;
         d_writes_rd <= writes_nxt;
         d_mret      <= mret_nxt;
         d_ecall     <= ecall_nxt;
         d_ebreak    <= ebreak_nxt;
         d_illegal   <= illegal_nxt;
      end else begin
         completed   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed cases plus random words against a mask/match table model.
module tb_decode;

   logic        clk = 1'b0;
   logic        rstn;
   logic        enabled;
   logic [31:0] pc;
   logic [31:0] instr_raw;
   logic        completed;
   logic [4:0]  rs1, rs2, d_rd;
   logic [31:0] d_pc, d_raw, d_imm;
   logic [5:0]  d_op;
   logic        d_jal, d_jalr, d_cond_jump, d_writes_rd;
   logic        d_mret, d_ecall, d_ebreak, d_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] imm;
      logic [7:0]  flags; // jal, jalr, cond, writes_rd, mret, ecall, ebreak, illegal
   } exp_t;

   exp_t        held;
   logic [31:0] held_pc, held_raw;

   // Canonical match values for ops 1..45 (index = op - 1).
   logic [31:0] t_match [45] = '{
      32'h37, 32'h17, 32'h6f, 32'h67,
      32'h63, 32'h1063, 32'h4063, 32'h5063, 32'h6063, 32'h7063,
      32'h03, 32'h1003, 32'h2003, 32'h4003, 32'h5003,
      32'h23, 32'h1023, 32'h2023,
      32'h13, 32'h2013, 32'h3013, 32'h4013, 32'h6013, 32'h7013,
      32'h1013, 32'h5013, 32'h40005013,
      32'h33, 32'h40000033, 32'h1033, 32'h2033, 32'h3033, 32'h4033, 32'h5033,
      32'h40005033, 32'h6033, 32'h7033,
      32'h02000033, 32'h02001033, 32'h02002033, 32'h02003033,
      32'h02004033, 32'h02005033, 32'h02006033, 32'h02007033};

   logic [6:0] opc_pool [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                                 7'h33, 7'h0f, 7'h73};
   logic [6:0] f7_pool [4] = '{7'h00, 7'h20, 7'h01, 7'h7f};

   decode dut (
      .clk(clk), .rstn(rstn), .enabled(enabled), .pc(pc), .instr_raw(instr_raw),
      .completed(completed), .rs1(rs1), .rs2(rs2), .d_pc(d_pc), .d_raw(d_raw),
      .d_rd(d_rd), .d_imm(d_imm), .d_op(d_op), .d_jal(d_jal), .d_jalr(d_jalr),
      .d_cond_jump(d_cond_jump), .d_writes_rd(d_writes_rd), .d_mret(d_mret),
      .d_ecall(d_ecall), .d_ebreak(d_ebreak), .d_illegal(d_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1);
   end

   function automatic exp_t model(input logic [31:0] w);
      exp_t        e;
      int          op;
      int          n_ops;
      logic [31:0] mask;
      e  = '0;
      op = 0;
`ifdef RV32M_EN
      n_ops = 45;
`else
      n_ops = 37;
`endif
      for (int i = 1; i <= n_ops; i++) begin
         mask = (i <= 3) ? 32'h7f : (i <= 24) ? 32'h707f : 32'hfe00707f;
         if ((w & mask) == t_match[i-1]) op = i;
      end
      e.op = 6'(op);
      if (op != 0) begin
         if (op <= 2)
            e.imm = {w[31:12], 12'h000};
         else if (op == 3)
            e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         else if (op >= 5 && op <= 10)
            e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         else if (op >= 16 && op <= 18)
            e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
         else if (op <= 27)
            e.imm = {{20{w[31]}}, w[31:20]};
         e.flags[7] = (op == 3);
         e.flags[6] = (op == 4);
         e.flags[5] = (op >= 5 && op <= 10);
         e.flags[4] = !(op >= 5 && op <= 10) && !(op >= 16 && op <= 18) && (w[11:7] != 0);
      end else if (w == 32'h30200073) e.flags[3] = 1'b1;
      else if (w == 32'h00000073)     e.flags[2] = 1'b1;
      else if (w == 32'h00100073)     e.flags[1] = 1'b1;
      else if (w[6:0] != 7'h0f)       e.flags[0] = 1'b1;
      return e;
   endfunction

   function automatic logic [31:0] gen_word();
      logic [31:0] w;
      int          r;
      w = $urandom;
      r = $urandom_range(0, 19);
      if (r < 16) w[6:0] = opc_pool[$urandom_range(0, 10)];
      if (r < 10) w[31:25] = f7_pool[$urandom_range(0, 3)];
      if (r == 16) w = 32'h30200073;
      if (r == 17) w = {11'h0, 1'($urandom_range(0, 1)), 20'h00073};
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; enabled = 1'b1; pc = 32'h44; instr_raw = 32'hFE208EE3;
      tick(); tick();
      n_checks++;
      if (completed !== 1'b0) begin
         n_fail++; $display("FAIL reset_completed: got %b, required 0", completed);
      end
      n_checks++;
      if ({d_pc, d_raw, d_imm, d_op, d_rd} !== '0) begin
         n_fail++; $display("FAIL reset_fields: got pc=%h raw=%h imm=%h op=%0d rd=%0d, required 0",
                            d_pc, d_raw, d_imm, d_op, d_rd);
      end
      n_checks++;
      if ({d_jal, d_jalr, d_cond_jump, d_writes_rd, d_mret, d_ecall, d_ebreak, d_illegal} !== 8'h0)
      begin
         n_fail++; $display("FAIL reset_flags: got nonzero flags, required 0");
      end
      n_checks++;
      if (rs1 !== 5'd1 || rs2 !== 5'd2) begin
         n_fail++; $display("FAIL reset_rs: got rs1=%0d rs2=%0d, required 1 2", rs1, rs2);
      end
      held = '0; held_pc = '0; held_raw = '0;
   endtask

   task automatic test_directed();
      rstn = 1'b1; enabled = 1'b1;
      pc = 32'h10; instr_raw = 32'h00500093;
      tick();
      n_checks++;
      if ({completed, d_op, d_rd, d_imm, d_writes_rd, d_pc} !== {1'b1, 6'd19, 5'd1, 32'd5, 1'b1, 32'h10})
      begin
         n_fail++; $display("FAIL addi: got c=%b op=%0d rd=%0d imm=%h wr=%b pc=%h, required 1 19 1 5 1 10",
                            completed, d_op, d_rd, d_imm, d_writes_rd, d_pc);
      end
      instr_raw = 32'hFE208EE3;
      #1;
      n_checks++;
      if (rs1 !== 5'd1 || rs2 !== 5'd2) begin
         n_fail++; $display("FAIL beq_rs: got rs1=%0d rs2=%0d, required 1 2", rs1, rs2);
      end
      tick();
      n_checks++;
      if ({d_op, d_cond_jump, d_imm, d_writes_rd} !== {6'd5, 1'b1, 32'hFFFFFFFC, 1'b0}) begin
         n_fail++; $display("FAIL beq: got op=%0d cj=%b imm=%h wr=%b, required 5 1 fffffffc 0",
                            d_op, d_cond_jump, d_imm, d_writes_rd);
      end
      instr_raw = 32'h123452B7;
      tick();
      n_checks++;
      if ({d_op, d_rd, d_imm} !== {6'd1, 5'd5, 32'h12345000}) begin
         n_fail++; $display("FAIL lui: got op=%0d rd=%0d imm=%h, required 1 5 12345000",
                            d_op, d_rd, d_imm);
      end
      instr_raw = 32'h30200073;
      tick();
      n_checks++;
      if ({d_mret, d_illegal, d_op, d_writes_rd} !== {1'b1, 1'b0, 6'd0, 1'b0}) begin
         n_fail++; $display("FAIL mret: got mret=%b ill=%b op=%0d wr=%b, required 1 0 0 0",
                            d_mret, d_illegal, d_op, d_writes_rd);
      end
      instr_raw = 32'hFFFFFFFF;
      tick();
      n_checks++;
      if ({d_illegal, d_op, d_mret} !== {1'b1, 6'd0, 1'b0}) begin
         n_fail++; $display("FAIL all_ones: got ill=%b op=%0d, required 1 0", d_illegal, d_op);
      end
      instr_raw = 32'h00000073;
      tick();
      n_checks++;
      if ({d_ecall, d_ebreak, d_illegal} !== 3'b100) begin
         n_fail++; $display("FAIL ecall: got ecall=%b ebreak=%b ill=%b, required 1 0 0",
                            d_ecall, d_ebreak, d_illegal);
      end
      instr_raw = 32'h00100073;
      tick();
      n_checks++;
      if ({d_ecall, d_ebreak, d_illegal} !== 3'b010) begin
         n_fail++; $display("FAIL ebreak: got ecall=%b ebreak=%b ill=%b, required 0 1 0",
                            d_ecall, d_ebreak, d_illegal);
      end
      instr_raw = 32'h0FF0000F;
      tick();
      n_checks++;
      if ({d_illegal, d_op, d_writes_rd} !== {1'b0, 6'd0, 1'b0}) begin
         n_fail++; $display("FAIL fence: got ill=%b op=%0d wr=%b, required 0 0 0",
                            d_illegal, d_op, d_writes_rd);
      end
      instr_raw = 32'h40009093; // slli with nonzero imm[11:5]
      tick();
      n_checks++;
      if ({d_illegal, d_op} !== {1'b1, 6'd0}) begin
         n_fail++; $display("FAIL slli_bad: got ill=%b op=%0d, required 1 0", d_illegal, d_op);
      end
      instr_raw = 32'h40105093;
      tick();
      n_checks++;
      if ({d_illegal, d_op} !== {1'b0, 6'd27}) begin
         n_fail++; $display("FAIL srai: got ill=%b op=%0d, required 0 27", d_illegal, d_op);
      end
      instr_raw = 32'h008000EF;
      tick();
      n_checks++;
      if ({d_jal, d_op, d_imm, d_writes_rd} !== {1'b1, 6'd3, 32'd8, 1'b1}) begin
         n_fail++; $display("FAIL jal: got jal=%b op=%0d imm=%h wr=%b, required 1 3 8 1",
                            d_jal, d_op, d_imm, d_writes_rd);
      end
      instr_raw = 32'h00500092;
      tick();
      n_checks++;
      if ({d_illegal, d_op, d_writes_rd} !== {1'b1, 6'd0, 1'b0}) begin
         n_fail++; $display("FAIL low_bits: got ill=%b op=%0d wr=%b, required 1 0 0",
                            d_illegal, d_op, d_writes_rd);
      end
      instr_raw = 32'h022081B3;
      tick();
      n_checks++;
`ifdef RV32M_EN
      if ({d_op, d_illegal, d_writes_rd} !== {6'd38, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL mul: got op=%0d ill=%b wr=%b, required 38 0 1",
                            d_op, d_illegal, d_writes_rd);
      end
`else
      if ({d_op, d_illegal, d_writes_rd} !== {6'd0, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL mul: got op=%0d ill=%b wr=%b, required 0 1 0",
                            d_op, d_illegal, d_writes_rd);
      end
`endif
   endtask

   task automatic test_hold();
      rstn = 1'b1; enabled = 1'b1; pc = 32'h20; instr_raw = 32'h00500093;
      tick();
      enabled = 1'b0; instr_raw = 32'hFFFFFFFF; pc = 32'h99;
      tick();
      n_checks++;
      if ({completed, d_op, d_illegal, d_pc, d_raw} !== {1'b0, 6'd19, 1'b0, 32'h20, 32'h00500093})
      begin
         n_fail++; $display("FAIL hold: got c=%b op=%0d ill=%b pc=%h raw=%h, required 0 19 0 20 00500093",
                            completed, d_op, d_illegal, d_pc, d_raw);
      end
      rstn = 1'b0;
      tick();
      n_checks++;
      if ({completed, d_op, d_rd, d_imm, d_pc, d_raw, d_writes_rd} !== '0) begin
         n_fail++; $display("FAIL hold_reset: got c=%b op=%0d pc=%h raw=%h, required all 0",
                            completed, d_op, d_pc, d_raw);
      end
   endtask

   task automatic test_reset_mid();
      rstn = 1'b0; enabled = 1'b1; instr_raw = 32'h123452B7; pc = 32'h7;
      tick();
      rstn = 1'b1; enabled = 1'b0;
      tick();
      n_checks++;
      if ({completed, d_op, d_raw} !== {1'b0, 6'd0, 32'h0}) begin
         n_fail++; $display("FAIL reset_discard: got c=%b op=%0d raw=%h, required 0 0 0",
                            completed, d_op, d_raw);
      end
      enabled = 1'b1;
      tick();
      n_checks++;
      if ({completed, d_op, d_pc} !== {1'b1, 6'd1, 32'h7}) begin
         n_fail++; $display("FAIL reset_first: got c=%b op=%0d pc=%h, required 1 1 7",
                            completed, d_op, d_pc);
      end
      held = model(32'h123452B7); held_pc = 32'h7; held_raw = 32'h123452B7;
   endtask

   task automatic test_random(input int n, input bit always_en);
      logic [31:0] w;
      logic        exp_c;
      rstn = 1'b1;
      for (int k = 0; k < n; k++) begin
         w         = gen_word();
         instr_raw = w;
         pc        = $urandom;
         enabled   = always_en ? 1'b1 : ($urandom_range(0, 3) != 0);
         exp_c     = enabled;
         if (enabled) begin
            held = model(w); held_pc = pc; held_raw = w;
         end
         #1;
         n_checks++;
         if (rs1 !== w[19:15] || rs2 !== w[24:20]) begin
            n_fail++; $display("FAIL rnd_rs w=%h: got %0d %0d, required %0d %0d",
                               w, rs1, rs2, w[19:15], w[24:20]);
         end
         tick();
         n_checks++;
         if (completed !== exp_c) begin
            n_fail++; $display("FAIL rnd_completed w=%h: got %b, required %b", w, completed, exp_c);
         end
         n_checks++;
         if (d_op !== held.op ||
             {d_jal, d_jalr, d_cond_jump, d_writes_rd, d_mret, d_ecall, d_ebreak, d_illegal}
             !== held.flags) begin
            n_fail++; $display("FAIL rnd_decode raw=%h: got op=%0d flags=%b, required op=%0d flags=%b",
                               held_raw, d_op,
                               {d_jal, d_jalr, d_cond_jump, d_writes_rd, d_mret, d_ecall,
                                d_ebreak, d_illegal}, held.op, held.flags);
         end
         n_checks++;
         if (d_pc !== held_pc || d_raw !== held_raw || d_rd !== held_raw[11:7]) begin
            n_fail++; $display("FAIL rnd_copy: got pc=%h raw=%h rd=%0d, required %h %h %0d",
                               d_pc, d_raw, d_rd, held_pc, held_raw, held_raw[11:7]);
         end
         if (held.op != 0) begin
            n_checks++;
            if (d_imm !== held.imm) begin
               n_fail++; $display("FAIL rnd_imm raw=%h: got %h, required %h",
                                  held_raw, d_imm, held.imm);
            end
         end
      end
   endtask

   initial begin
      rstn = 1'b0; enabled = 1'b0; pc = '0; instr_raw = '0;
      test_reset();
      test_directed();
      test_hold();
      test_reset_mid();
      test_random(400, 1'b0);
      test_random(100, 1'b1); // back-to-back decodes
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
